// File: rtl/svm_pkg.sv
// Shared definitions for the SVM front end.
// Holds the default vector geometry, the modality tag type and the
// saturation bounds of the NBITS signed feature format.
package svm_pkg;

    localparam int unsigned NBITS       = 9;
    localparam int unsigned F_WIDTH     = 214;
    localparam int unsigned LOG_F_WIDTH = 8;

    typedef enum logic {
        MOD_VALENCE = 1'b0,
        MOD_AROUSAL = 1'b1
    } modality_t;

    localparam int sat_max = (1 << (NBITS - 1)) - 1;
    localparam int sat_min = -(1 << (NBITS - 1));

endpackage

// File: rtl/svm_quantize.sv
// Sample quantizer: arithmetic right shift (floor) followed by saturation
// to the NBITS signed range.
// Ports:
//   din     - signed input sample (IN_BITS)
//   q       - quantized, saturated sample (NBITS, signed)
//   clipped - high when saturation changed the value
module svm_quantize #(
    parameter int unsigned NBITS   = 9,
    parameter int unsigned IN_BITS = 16,
    parameter int unsigned SHIFT   = 4
) (
    input  logic signed [IN_BITS-1:0] din,
    output logic signed [NBITS-1:0]   q,
    output logic                      clipped
);

    localparam logic signed [IN_BITS-1:0] QMax = IN_BITS'((1 << (NBITS - 1)) - 1);
    localparam logic signed [IN_BITS-1:0] QMin = IN_BITS'(-(1 << (NBITS - 1)));

    logic signed [IN_BITS-1:0] shifted;

    always_comb begin
        shifted = din >>> SHIFT;
        q       = shifted[NBITS-1:0];
        clipped = 1'b0;
        if (shifted > QMax) begin
            q       = QMax[NBITS-1:0];
            clipped = 1'b1;
        end else if (shifted < QMin) begin
            q       = QMin[NBITS-1:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/svm_feature_packer.sv
// Serial-to-parallel feature packer feeding the SVM.
// Quantizes each accepted sample, writes it into the filling half of a
// two-entry vector buffer and presents the oldest complete vector with its
// modality tag on a valid/ready handshake.
// Ports:
//   clk, rst                - clock, asynchronous active-low reset
//   din/din_valid/din_last  - sample stream in; din_ready = buffer not full
//   out_features            - packed vector, feature j at [j*NBITS +: NBITS]
//   out_modality/out_valid  - tag and valid of the presented vector
//   out_ready               - downstream accepts the presented vector
//   err_frame               - sticky din_last position error
//   sat_cnt                 - saturating count of clipped samples
module svm_feature_packer #(
    parameter int unsigned NBITS       = svm_pkg::NBITS,
    parameter int unsigned F_WIDTH     = svm_pkg::F_WIDTH,
    parameter int unsigned LOG_F_WIDTH = svm_pkg::LOG_F_WIDTH,
    parameter int unsigned IN_BITS     = 16,
    parameter int unsigned SHIFT       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [IN_BITS-1:0]  din,
    input  logic                       din_valid,
    input  logic                       din_last,
    output logic                       din_ready,
    output logic [NBITS*F_WIDTH-1:0]   out_features,
    output logic                       out_modality,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err_frame,
    output logic [15:0]                sat_cnt
);
    import svm_pkg::*;

    localparam int unsigned           VW      = NBITS * F_WIDTH;
    localparam logic [LOG_F_WIDTH-1:0] LastIdx = LOG_F_WIDTH'(F_WIDTH - 1);

    logic [VW-1:0]          vbuf_q [2];
    logic [VW-1:0]          vbuf_d [2];
    modality_t              vmod_q [2];
    modality_t              vmod_d [2];
    logic [1:0]             count_q, count_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [LOG_F_WIDTH-1:0] idx_q, idx_d;
    modality_t              wr_mod_q, wr_mod_d;
    logic                   err_q, err_d;
    logic [15:0]            sat_q, sat_d;

    logic signed [NBITS-1:0] q;
    logic                    clipped;
    logic                    accept, at_end, complete, pop;

    svm_quantize #(
        .NBITS   (NBITS),
        .IN_BITS (IN_BITS),
        .SHIFT   (SHIFT)
    ) u_quantize (
        .din     (din),
        .q       (q),
        .clipped (clipped)
    );

    assign din_ready    = (count_q != 2'd2);
    assign out_valid    = (count_q != 2'd0);
    assign out_features = vbuf_q[rd_ptr_q];
    assign out_modality = vmod_q[rd_ptr_q];
    assign err_frame    = err_q;
    assign sat_cnt      = sat_q;

    assign accept   = din_valid && din_ready;
    assign at_end   = (idx_q == LastIdx);
    assign complete = accept && (at_end || din_last);
    assign pop      = out_valid && out_ready;

    always_comb begin
        vbuf_d   = vbuf_q;
        vmod_d   = vmod_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        wr_mod_d = wr_mod_q;
        err_d    = err_q;
        sat_d    = sat_q;

        if (accept) begin
            for (int b = 0; b < 2; b++) begin
                if (b[0] == wr_ptr_q) begin
                    for (int j = 0; j < F_WIDTH; j++) begin
                        if (LOG_F_WIDTH'(j) == idx_q) begin
                            vbuf_d[b][j*NBITS +: NBITS] = q;
                        end else if (din_last && (LOG_F_WIDTH'(j) > idx_q)) begin
                            // Early end: clear the tail left over from an older vector.
                            vbuf_d[b][j*NBITS +: NBITS] = '0;
                        end
                    end
                end
            end
            idx_d = idx_q + 1'b1;
            if (clipped && (sat_q != 16'hFFFF)) begin
                sat_d = sat_q + 16'd1;
            end
        end

        if (complete) begin
            vmod_d[wr_ptr_q] = wr_mod_q;
            wr_mod_d         = modality_t'(~wr_mod_q);
            wr_ptr_d         = ~wr_ptr_q;
            idx_d            = '0;
            // Framing is correct only when din_last lands exactly on the final slot.
            if (at_end != din_last) begin
                err_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({complete, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                vbuf_q[b] <= '0;
                vmod_q[b] <= MOD_VALENCE;
            end
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            idx_q    <= '0;
            wr_mod_q <= MOD_VALENCE;
            err_q    <= 1'b0;
            sat_q    <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                vbuf_q[b] <= vbuf_d[b];
                vmod_q[b] <= vmod_d[b];
            end
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            wr_mod_q <= wr_mod_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: doc/svm_feature_packer.md
Name: svm_feature_packer

Overview:
Upstream stage of the SVM classifier. It accepts extracted features as a serial stream, one sample per cycle. Each sample is quantized to NBITS signed fixed point with saturation and packed into the flat NBITS*F_WIDTH feature bus the SVM consumes on its fin_valid/fin_ready handshake. A two-entry vector buffer (ping-pong) lets the next vector fill while the SVM holds the current one. Vectors alternate valence/arousal, and a modality tag goes out with each vector.

Parameters:
NBITS, 9, output feature width (signed)
F_WIDTH, 214, features per vector
LOG_F_WIDTH, 8, ceilLog2(F_WIDTH), index counter width
IN_BITS, 16, input sample width (signed)
SHIFT, 4, arithmetic right shift applied before saturation

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
din  in  IN_BITS  signed feature sample
din_valid  in  1  sample valid
din_last  in  1  marks final sample of a vector
din_ready  out  1  packer can accept a sample
out_features  out  NBITS*F_WIDTH  packed vector; feature j at [j*NBITS +: NBITS]
out_modality  out  1  0 = valence, 1 = arousal
out_valid  out  1  vector available
out_ready  in  1  downstream (SVM fin_ready) accepts
err_frame  out  1  sticky: din_last position mismatch seen
sat_cnt  out  16  saturating count of clipped samples

Behaviour:
- Reset (rst=0, asynchronous): count=0, wr_ptr=rd_ptr=0, idx=0, wr_mod=0, both buffers zeroed, err_frame=0, sat_cnt=0.
- Outputs while in reset: out_valid=0, out_features=0, out_modality=0, din_ready=1.
- State: buf[0..1] of F_WIDTH×NBITS, per-buffer modality bit, count (0..2), wr_ptr, rd_ptr, idx (0..F_WIDTH-1), wr_mod.
- din_ready = (count<2), combinational. A sample is accepted when din_valid && din_ready.
- Quantize: q = din >>> SHIFT (floor). Then saturate to [-2^(NBITS-1), 2^(NBITS-1)-1].
- sat_cnt increments by 1 per accepted sample that clipped, and holds at 0xFFFF.
- Accepted sample: buf[wr_ptr][idx] <= q, then idx++.
- Vector completes on an accepted sample when idx==F_WIDTH-1 OR din_last=1.
- On completion:
  - buf modality <= wr_mod; wr_mod toggles; wr_ptr flips; idx <= 0; count++.
  - Early last (idx<F_WIDTH-1): entries idx+1..F_WIDTH-1 of that buffer are written 0 in the same cycle, and err_frame <= 1.
  - Late/missing last (idx==F_WIDTH-1, din_last=0): vector still completes, and err_frame <= 1.
- Output: out_valid = (count>0). out_features and out_modality come from buf[rd_ptr] and are registered, not combinational from din.
- Latency: the completing sample is accepted at edge t; out_valid=1 from edge t (visible in cycle t+1) when count was 0.
- Output transfer: on out_valid && out_ready, rd_ptr flips and count--.
- Same-cycle completion and output transfer: count unchanged, both pointers flip.
- Hold: while out_valid && !out_ready, out_features and out_modality stay stable.
- Full: count==2 gives din_ready=0; idx and buffers are frozen, and din is ignored.
- Mid-operation reset: the partial vector and any buffered vectors are discarded, and the modality restarts at valence.

Decomposition:
- svm_pkg holds: NBITS, F_WIDTH, LOG_F_WIDTH localparams; the modality_t enum {MOD_VALENCE=0, MOD_AROUSAL=1}; sat_max/sat_min constants.
- Sub-module svm_quantize: combinational shift plus saturate, with output q and flag clipped. The packer instantiates it once.

Test Plan:
1. Stream 214 samples din=16*j (j=0..213, clipped past 255), out_ready=1 -> out_valid 1 cycle after last; feature j = min(j,255), i.e. j for all j here; out_modality=0; err_frame=0.
2. Quantization: din=0x0FF0→255, 0x1000→255, 0xFFEF(-17)→-2, 0xE000(-8192)→-256 -> sat_cnt=2 after these four.
3. Backpressure: out_ready=0, send 3 vectors -> out_valid after the 1st, din_ready=0 after the 2nd completes, the 3rd stalls. Raise out_ready -> vectors come out in order with modality 0,1, then the 3rd fills (modality 0).
4. Early din_last at sample 100 (idx 99) -> vector emitted, features 100..213 = 0, err_frame=1 and remains 1.
5. Simultaneous: count=1 and out_ready=1 in the cycle the 2nd vector completes -> count remains 1, out_features switch to the 2nd vector the next cycle.
6. Assert rst low mid-vector (idx=57) -> out_valid=0, din_ready=1, idx=0, sat_cnt=0. The next full vector emits with out_modality=0.
